csr_arbiter: RTL and testbench
==============================

Name: csr_arbiter

Overview:
- Shares the single internal CSR bus (5-bit address, 8-bit data, write strobe, 1-cycle registered read data) between two requesters.
- Typical requesters: the host-facing bridge (m0) and an internal sequencer (m1).
- Accepts one request at a time and issues a single-cycle CSR access.
- Waits out the peripherals' registered read latency, then returns read data with a one-cycle ack.
- Sits between the requesters and the CSR register blocks (GPO, GPI, etc.) that decode csr_a.

Parameters:
- READ_LATENCY, 1, cycles from CSR address issue to valid csr_do; legal range 1..4.
- IDLE_ADDR, 5'h1f, parking address driven on csr_a when no access is in flight; must not be decoded by any peripheral.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  m0 request; held together with m0_a/m0_di/m0_we until m0_ack.
- m0_a  in  5  m0 CSR address.
- m0_di  in  8  m0 write data.
- m0_we  in  1  m0 write (1) / read (0).
- m0_ack  out  1  one-cycle completion pulse for m0.
- m0_do  out  8  m0 read data; valid with m0_ack and held until the next m0_ack.
- m1_req, m1_a, m1_di, m1_we, m1_ack, m1_do: same as m0.
- csr_a  out  5  CSR address to peripherals.
- csr_di  out  8  CSR write data.
- csr_we  out  1  CSR write strobe.
- csr_do  in  8  OR-combined registered read data from peripherals.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, csr_a=IDLE_ADDR, csr_di=0, csr_we=0.
  - m0_ack=m1_ack=0, m0_do=m1_do=0, wait counter=0, last=1 (m0 wins the first contention).
- Reset mid-transaction aborts it with no ack. A write already strobed is not undone.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is sampled high, pick a winner: the sole requester, or the requester != last if both.
  - Latch the winner's a/di/we into csr_a/csr_di/csr_we, set last=winner, go to ISSUE.
  - With no req: stay in IDLE, csr_a=IDLE_ADDR, csr_we=0.
- ISSUE (exactly 1 cycle):
  - csr_a/csr_di driven; csr_we=latched we. This is the only cycle csr_we can be high.
  - Load counter=READ_LATENCY-1, go to WAIT.
- WAIT:
  - csr_a held, csr_we=0.
  - If counter==0: capture csr_do into winner's mN_do (reads and writes alike; a write returns post-write readback) and go to DONE.
  - Else decrement the counter.
- DONE (1 cycle):
  - Winner's mN_ack=1; csr_a=IDLE_ADDR; go to IDLE.
  - The loser's ack and do are untouched.
- Latency with READ_LATENCY=1: req sampled at T0, csr_we at T1, csr_do captured at end of T2, ack at T3, IDLE at T4. Minimum 4 cycles per access.
- A req still high in the cycle after ack (the IDLE cycle) is a new transaction.
- The requester's a/di/we are sampled only in IDLE. Changes after acceptance are ignored.
- Simultaneous requests always alternate, so neither requester waits more than one other transaction.
- A req dropped before its ack is not cancelled; the access completes and ack still pulses.

Optional Feature:
- Macro: CSR_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins contention; the last register is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package/include csr_pkg:
  - CSR_AW=5, CSR_DW=8.
  - FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3).
  - Requester index constants M0=0, M1=1.
- Sub-module csr_arb_pick: combinational winner selection from req[1:0] and last, with the CSR_ARB_FIXED_PRIO_EN variant inside.
- The FSM, counter and datapath stay in csr_arbiter.

Test Plan:
- Single read: m0 read a=5'h02, csr_do returns 8'h5a one cycle after ISSUE -> csr_we never high, m0_ack 3 cycles after req sampled, m0_do=8'h5a, m1_ack stays 0.
- Single write: m1 write a=5'h03, di=8'hc3 -> csr_we high for exactly one cycle with csr_a=5'h03, csr_di=8'hc3. m1_do=readback, m1_ack pulses once.
- Contention, reqs held high: m0 and m1 both request after reset -> grant order m0, m1, m0, m1. Each ack 4 cycles apart. Fixed-prio build: m0 only while m0_req is held.
- Latency: READ_LATENCY=3, m0 read -> csr_a held 4 cycles (ISSUE + 3 WAIT), ack at T5, data captured from the last WAIT cycle.
- Reset mid-op: assert rst during WAIT -> outputs reset immediately, csr_a=5'h1f, no ack. After release, a pending m1_req is served normally.
- Idle parking: no requests for 10 cycles -> csr_a=5'h1f, csr_we=0, acks 0 throughout.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared widths, FSM encoding and requester indices for the CSR bus arbiter.
package csr_pkg;

    localparam int CSR_AW = 5;
    localparam int CSR_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/csr_arb_pick.sv
// Combinational winner selection between the two CSR requesters.
// Build option CSR_ARB_FIXED_PRIO_EN: m0 always wins and no history input exists.
module csr_arb_pick
    import csr_pkg::*;
(
    input  logic [1:0] req,
`ifndef CSR_ARB_FIXED_PRIO_EN
    input  logic       last,
`endif
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
`ifdef CSR_ARB_FIXED_PRIO_EN
        winner = req[0] ? M0 : M1;
`else
        // On contention the requester that was not served last goes next.
        case (req)
            2'b01:   winner = M0;
            2'b10:   winner = M1;
            2'b11:   winner = ~last;
            default: winner = M0;
        endcase
`endif
    end

endmodule

// File: rtl/csr_arbiter.sv
// Two-requester arbiter for the internal CSR bus: one access at a time, waits out
// the peripherals' read latency, then acks the winner. Build option: CSR_ARB_FIXED_PRIO_EN.
module csr_arbiter
    import csr_pkg::*;
#(
    parameter int                READ_LATENCY = 1,
    parameter logic [CSR_AW-1:0] IDLE_ADDR    = 5'h1f
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [CSR_AW-1:0] m0_a,
    input  logic [CSR_DW-1:0] m0_di,
    input  logic              m0_we,
    output logic              m0_ack,
    output logic [CSR_DW-1:0] m0_do,
    input  logic              m1_req,
    input  logic [CSR_AW-1:0] m1_a,
    input  logic [CSR_DW-1:0] m1_di,
    input  logic              m1_we,
    output logic              m1_ack,
    output logic [CSR_DW-1:0] m1_do,
    output logic [CSR_AW-1:0] csr_a,
    output logic [CSR_DW-1:0] csr_di,
    output logic              csr_we,
    input  logic [CSR_DW-1:0] csr_do
);

    localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

    arb_state_t        state, next_state;
    logic [1:0]        cnt, cnt_nxt;
    logic              owner, owner_nxt;
    logic              grant_valid, grant;
    logic [CSR_AW-1:0] csr_a_nxt;
    logic [CSR_DW-1:0] csr_di_nxt, m0_do_nxt, m1_do_nxt;
    logic              csr_we_nxt, m0_ack_nxt, m1_ack_nxt;

    csr_arb_pick u_pick (
        .req    ({m1_req, m0_req}),
`ifndef CSR_ARB_FIXED_PRIO_EN
        .last   (owner),
`endif
        .valid  (grant_valid),
        .winner (grant)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == 2'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every *_nxt gets a hold/default value first so no path infers a latch.
    always_comb begin
        csr_a_nxt  = csr_a;
        csr_di_nxt = csr_di;
        csr_we_nxt = 1'b0;
        m0_ack_nxt = 1'b0;
        m1_ack_nxt = 1'b0;
        m0_do_nxt  = m0_do;
        m1_do_nxt  = m1_do;
        owner_nxt  = owner;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    owner_nxt  = grant;
                    csr_a_nxt  = (grant == M1) ? m1_a  : m0_a;
                    csr_di_nxt = (grant == M1) ? m1_di : m0_di;
                    csr_we_nxt = (grant == M1) ? m1_we : m0_we;
                end else begin
                    csr_a_nxt = IDLE_ADDR;
                end
            end
            ISSUE: cnt_nxt = CNT_LOAD;
            WAIT: begin
                if (cnt == 2'd0) begin
                    // Writes capture too, returning the post-write readback.
                    if (owner == M1) begin
                        m1_do_nxt  = csr_do;
                        m1_ack_nxt = 1'b1;
                    end else begin
                        m0_do_nxt  = csr_do;
                        m0_ack_nxt = 1'b1;
                    end
                    csr_a_nxt = IDLE_ADDR;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_a  <= IDLE_ADDR;
            csr_di <= '0;
            csr_we <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_do  <= '0;
            m1_do  <= '0;
            owner  <= M1;
            cnt    <= '0;
        end else begin
            csr_a  <= csr_a_nxt;
            csr_di <= csr_di_nxt;
            csr_we <= csr_we_nxt;
            m0_ack <= m0_ack_nxt;
            m1_ack <= m1_ack_nxt;
            m0_do  <= m0_do_nxt;
            m1_do  <= m1_do_nxt;
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: one instance at READ_LATENCY=1, one at 3,
// each with a small registered peripheral model on the CSR side.
module tb_csr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [4:0] m0_a, m1_a, csr_a;
    logic [7:0] m0_di, m1_di, m0_do, m1_do, csr_di, csr_do;
    logic       csr_we;

    logic       l_req, l_ack, l_m1_ack, l_csr_we;
    logic [4:0] l_a, l_csr_a;
    logic [7:0] l_do, l_m1_do, l_csr_di, l_csr_do;

    csr_arbiter #(.READ_LATENCY(1), .IDLE_ADDR(5'h1f)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_a(m0_a), .m0_di(m0_di), .m0_we(m0_we), .m0_ack(m0_ack), .m0_do(m0_do),
        .m1_req(m1_req), .m1_a(m1_a), .m1_di(m1_di), .m1_we(m1_we), .m1_ack(m1_ack), .m1_do(m1_do),
        .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do)
    );

    csr_arbiter #(.READ_LATENCY(3), .IDLE_ADDR(5'h1f)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(l_req), .m0_a(l_a), .m0_di(8'h00), .m0_we(1'b0), .m0_ack(l_ack), .m0_do(l_do),
        .m1_req(1'b0), .m1_a(5'h00), .m1_di(8'h00), .m1_we(1'b0), .m1_ack(l_m1_ack), .m1_do(l_m1_do),
        .csr_a(l_csr_a), .csr_di(l_csr_di), .csr_we(l_csr_we), .csr_do(l_csr_do)
    );

    // Peripheral model: registered read, write-through readback, 0x1f undecoded.
    logic [7:0] mem [32];
    logic [7:0] d1, d2, d3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mem[2] <= 8'h5a; mem[4] <= 8'h11; mem[5] <= 8'h22;
            mem[6] <= 8'h33; mem[7] <= 8'h7e;
            csr_do <= 8'h00;
            d1 <= 8'h00; d2 <= 8'h00; d3 <= 8'h00;
        end else begin
            if (csr_we) mem[csr_a] <= csr_di;
            csr_do <= csr_we ? csr_di : ((csr_a == 5'h1f) ? 8'h00 : mem[csr_a]);
            d1 <= (l_csr_a == 5'h1f) ? 8'h00 : mem[l_csr_a];
            d2 <= d1;
            d3 <= d2;
        end
    end
    assign l_csr_do = d3;

    int we_cnt, a0_cnt, a1_cnt;
    always @(negedge clk) begin
        if (!rst) begin
            if (csr_we) we_cnt++;
            if (m0_ack) a0_cnt++;
            if (m1_ack) a1_cnt++;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        we_cnt = 0; a0_cnt = 0; a1_cnt = 0;
    endtask

    int n;
    int ng;
    int gw [8];
    int gc [8];

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_a = 0; m0_di = 0;
        m1_req = 0; m1_we = 0; m1_a = 0; m1_di = 0;
        l_req = 0; l_a = 0;
        clear_counts();
        tick(); tick();

        // Reset values
        check("rst_csr_a", csr_a, 5'h1f);
        check("rst_csr_we", csr_we, 1'b0);
        check("rst_csr_di", csr_di, 8'h00);
        check("rst_acks", {m0_ack, m1_ack}, 2'b00);
        check("rst_do", {m0_do, m1_do}, 16'h0000);
        check("rst_l_csr_a", l_csr_a, 5'h1f);
        rst = 1'b0;

        // Idle parking
        for (int i = 0; i < 10; i++) begin
            tick();
            check("park", {csr_a, csr_we, m0_ack, m1_ack}, {5'h1f, 3'b000});
        end

        // Single read by m0
        clear_counts();
        m0_a = 5'h02; m0_we = 1'b0; m0_req = 1'b1;
        tick();
        check("rd_issue_a", csr_a, 5'h02);
        check("rd_issue_we", csr_we, 1'b0);
        tick();
        check("rd_t2_ack", m0_ack, 1'b0);
        tick();
        check("rd_ack", m0_ack, 1'b1);
        check("rd_do", m0_do, 8'h5a);
        check("rd_done_a", csr_a, 5'h1f);
        m0_req = 1'b0;
        tick();
        check("rd_ack_drop", m0_ack, 1'b0);
        check("rd_we_cnt", we_cnt, 0);
        check("rd_a0_cnt", a0_cnt, 1);
        check("rd_a1_cnt", a1_cnt, 0);

        // Single write by m1
        clear_counts();
        m1_a = 5'h03; m1_di = 8'hc3; m1_we = 1'b1; m1_req = 1'b1;
        tick();
        check("wr_issue", {csr_we, csr_a, csr_di}, {1'b1, 5'h03, 8'hc3});
        n = 1;
        while (m1_ack !== 1'b1 && n < 10) begin tick(); n++; end
        check("wr_lat", n, 3);
        check("wr_do", m1_do, 8'hc3);
        m1_req = 1'b0; m1_we = 1'b0;
        tick();
        check("wr_we_cnt", we_cnt, 1);
        check("wr_a1_cnt", a1_cnt, 1);
        check("wr_a0_cnt", a0_cnt, 0);
        check("wr_m0_do_kept", m0_do, 8'h5a);

        // Contention from reset, both requests held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_counts();
        m0_a = 5'h04; m1_a = 5'h05; m0_req = 1'b1; m1_req = 1'b1;
        ng = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (m0_ack && ng < 8) begin gw[ng] = 0; gc[ng] = c; ng++; end
            if (m1_ack && ng < 8) begin gw[ng] = 1; gc[ng] = c; ng++; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("arb_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef CSR_ARB_FIXED_PRIO_EN
            check("arb_who", gw[k], 0);
`else
            check("arb_who", gw[k], k % 2);
`endif
            check("arb_cycle", gc[k], 3 + 4 * k);
        end
        check("arb_m0_do", m0_do, 8'h11);
`ifdef CSR_ARB_FIXED_PRIO_EN
        check("arb_m1_do", m1_do, 8'h00);
`else
        check("arb_m1_do", m1_do, 8'h22);
`endif
        tick(); tick();
        check("arb_idle", {csr_a, csr_we}, {5'h1f, 1'b0});

        // Reset during WAIT, pending m1 served afterwards
        clear_counts();
        m0_a = 5'h04; m0_req = 1'b1;
        tick(); tick();
        m0_req = 1'b0;
        m1_a = 5'h06; m1_we = 1'b0; m1_req = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_a", csr_a, 5'h1f);
        check("mid_rst_we_ack", {csr_we, m0_ack, m1_ack}, 3'b000);
        check("mid_rst_do", m0_do, 8'h00);
        tick();
        rst = 1'b0;
        n = 0;
        while (m1_ack !== 1'b1 && n < 10) begin tick(); n++; end
        check("post_rst_lat", n, 3);
        check("post_rst_do", m1_do, 8'h33);
        m1_req = 1'b0;
        tick();
        check("post_rst_a0", a0_cnt, 0);
        check("post_rst_a1", a1_cnt, 1);

        // READ_LATENCY=3 instance
        l_a = 5'h07; l_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) check("lat_hold_a", l_csr_a, 5'h07);
            check("lat_ack", l_ack, (c == 5) ? 1'b1 : 1'b0);
            check("lat_we", l_csr_we, 1'b0);
            if (c == 5) begin
                check("lat_do", l_do, 8'h7e);
                check("lat_done_a", l_csr_a, 5'h1f);
                l_req = 1'b0;
            end
        end
        check("lat_m1_quiet", {l_m1_ack, l_m1_do, l_csr_di}, 17'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
